key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 135 +++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronizes a raw active-low key, debounces press and
// release, and produces level, edge pulses, a long-press pulse and an LED toggle.
module key_debounce #(
  parameter logic [31:0] DEBOUNCE_CNT = 32'd1000000,
  parameter logic [31:0] LONG_CNT     = 32'd50000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic led_toggle
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        key_s_q, key_s_d;
  logic [31:0] db_cnt_q, db_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        long_done_q, long_done_d;
  logic        key_level_q, key_level_d;
  logic        key_press_q, key_press_d;
  logic        key_release_q, key_release_d;
  logic        key_long_q, key_long_d;
  logic        led_toggle_q, led_toggle_d;

  always_comb begin
    sync1_d       = key_n;
    key_s_d       = sync1_q;
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    long_done_d   = long_done_q;
    key_level_d   = key_level_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    key_long_d    = 1'b0;
    led_toggle_d  = led_toggle_q;

    // Hold timer runs through release debounce too, so a glitch never restarts it.
    if ((state_q == PRESSED || state_q == RELEASE_DB) && !long_done_q) begin
      if (hold_cnt_q == LONG_CNT - 32'd1) begin
        key_long_d  = 1'b1;
        long_done_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 32'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = 32'd0;
        end
      end
      PRESS_DB: begin
        if (key_s_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DEBOUNCE_CNT - 32'd1) begin
          state_d      = PRESSED;
          key_press_d  = 1'b1;
          key_level_d  = 1'b1;
          led_toggle_d = ~led_toggle_q;
          hold_cnt_d   = 32'd0;
          long_done_d  = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end
      PRESSED: begin
        if (key_s_q) begin
          state_d  = RELEASE_DB;
          db_cnt_d = 32'd0;
        end
      end
      RELEASE_DB: begin
        if (!key_s_q) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DEBOUNCE_CNT - 32'd1) begin
          state_d       = IDLE;
          key_release_d = 1'b1;
          key_level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q       <= 1'b1;
      key_s_q       <= 1'b1;
      state_q       <= IDLE;
      db_cnt_q      <= 32'd0;
      hold_cnt_q    <= 32'd0;
      long_done_q   <= 1'b0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_long_q    <= 1'b0;
      led_toggle_q  <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      key_s_q       <= key_s_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      long_done_q   <= long_done_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
      led_toggle_q  <= led_toggle_d;
    end
  end

  assign key_level   = key_level_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;
  assign led_toggle  = led_toggle_q;

endmodule
